// File: rtl/hs4_pkg.sv
// Shared definitions for the four-phase transmit queue.
package hs4_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2,
    ERR  = 2'd3
  } state_t;

endpackage

// File: rtl/hs4_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data and registered status.
module hs4_sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level_d;
  logic              do_wr;
  logic              do_rd;

  always_comb begin
    do_wr   = wr && !full;
    do_rd   = rd && !empty;
    level_d = level + LW'(do_wr) - LW'(do_rd);
  end

  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      level <= level_d;
      full  <= (level_d == LW'(DEPTH));
      empty <= (level_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/hs4_tx_queue.sv
// Queued four-phase req/ack transmitter with ack synchronizer, timeout and sent counter.
module hs4_tx_queue
  import hs4_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned SYNC    = 2,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   req,
  output logic [DATA_W-1:0]      data_out,
  input  logic                   ack,
  output logic                   busy,
  output logic                   timeout_err,
  input  logic                   clear_err,
  output logic [CNT_W-1:0]       sent_count
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_t            state;
  state_t            state_d;
  logic [SYNC-1:0]   sync_q;
  logic              ack_s;
  logic [TW-1:0]     tcnt;
  logic [TW-1:0]     tcnt_d;
  logic              req_d;
  logic              pop;
  logic              sent_inc;
  logic              to_hit;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_empty;

  hs4_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr      (wr_en),
    .wr_data (wr_data),
    .rd      (pop),
    .rd_data (fifo_data),
    .full    (full),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign ack_s = sync_q[SYNC-1];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // A waiting phase times out on its TIMEOUT-th cycle unless ack_s moves in that cycle.
  always_comb begin
    state_d  = state;
    req_d    = req;
    tcnt_d   = tcnt;
    pop      = 1'b0;
    sent_inc = 1'b0;
    to_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !ack_s) begin
          pop     = 1'b1;
          req_d   = 1'b1;
          tcnt_d  = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_s) begin
          req_d   = 1'b0;
          tcnt_d  = '0;
          state_d = DROP;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          to_hit  = 1'b1;
          req_d   = 1'b0;
          state_d = ERR;
        end else begin
          tcnt_d = tcnt + TW'(1);
        end
      end
      DROP: begin
        if (!ack_s) begin
          sent_inc = 1'b1;
          state_d  = IDLE;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          to_hit  = 1'b1;
          req_d   = 1'b0;
          state_d = ERR;
        end else begin
          tcnt_d = tcnt + TW'(1);
        end
      end
      ERR: begin
        req_d = 1'b0;
        if (clear_err && !ack_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Flag set events take priority over a same-cycle clear_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      tcnt        <= '0;
      req         <= 1'b0;
      data_out    <= '0;
      busy        <= 1'b0;
      sent_count  <= '0;
      timeout_err <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      sync_q <= SYNC'({sync_q, ack});
      tcnt   <= tcnt_d;
      req    <= req_d;
      busy   <= (state_d != IDLE);
      if (pop)      data_out   <= fifo_data;
      if (sent_inc) sent_count <= sent_count + CNT_W'(1);
      if (to_hit)         timeout_err <= 1'b1;
      else if (clear_err) timeout_err <= 1'b0;
      if (wr_en && full)  overflow <= 1'b1;
      else if (clear_err) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hs4_tx_queue.sv
// Randomized self-checking bench for hs4_tx_queue against a queue-based transfer model.
module tb_hs4_tx_queue;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned SYNC    = 2;
  localparam int unsigned TIMEOUT = 10;
  localparam int unsigned CNT_W   = 4;
  localparam int P_IDLE = 0, P_REQ = 1, P_DROP = 2, P_ERR = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              ack = 1'b0;
  logic              clear_err = 1'b0;
  logic              full, overflow, req, busy, timeout_err;
  logic [2:0]        level;
  logic [DATA_W-1:0] data_out;
  logic [CNT_W-1:0]  sent_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hs4_tx_queue #(
    .DATA_W (DATA_W), .DEPTH (DEPTH), .SYNC (SYNC), .TIMEOUT (TIMEOUT), .CNT_W (CNT_W)
  ) dut (
    .clk (clk), .rst (rst), .wr_en (wr_en), .wr_data (wr_data), .full (full),
    .level (level), .overflow (overflow), .req (req), .data_out (data_out),
    .ack (ack), .busy (busy), .timeout_err (timeout_err), .clear_err (clear_err),
    .sent_count (sent_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: words waiting, the word on the link, and the handshake phase.
  logic [DATA_W-1:0] m_q[$];
  bit                m_hist[$];
  int                m_phase = P_IDLE;
  int                m_age = 0;
  int                m_sent = 0;
  bit                m_req = 0, m_ovf = 0, m_terr = 0, m_valid = 0;
  logic [DATA_W-1:0] m_dout = '0;

  always @(posedge clk) begin : model
    bit ack_seen, was_full, hit;
    if (rst) begin
      m_q.delete();
      m_hist.delete();
      for (int i = 0; i < int'(SYNC); i++) m_hist.push_back(1'b0);
      m_phase = P_IDLE; m_age = 0; m_sent = 0;
      m_req = 0; m_ovf = 0; m_terr = 0; m_dout = '0; m_valid = 1;
    end else if (m_valid) begin
      ack_seen = m_hist[0];
      was_full = (m_q.size() == int'(DEPTH));
      hit = 0;
      case (m_phase)
        P_IDLE: if (m_q.size() > 0 && !ack_seen) begin
          m_dout = m_q.pop_front(); m_req = 1; m_phase = P_REQ; m_age = 0;
        end
        P_REQ, P_DROP: begin
          m_age++;
          if (m_phase == P_REQ && ack_seen) begin
            m_req = 0; m_phase = P_DROP; m_age = 0;
          end else if (m_phase == P_DROP && !ack_seen) begin
            m_sent = (m_sent + 1) % (1 << CNT_W); m_phase = P_IDLE;
          end else if (m_age == int'(TIMEOUT)) begin
            hit = 1; m_req = 0; m_phase = P_ERR;
          end
        end
        default: if (clear_err && !ack_seen) m_phase = P_IDLE;
      endcase
      if (wr_en && !was_full) m_q.push_back(wr_data);
      if (hit) m_terr = 1; else if (clear_err) m_terr = 0;
      if (wr_en && was_full) m_ovf = 1; else if (clear_err) m_ovf = 0;
      m_hist.push_back(ack);
      void'(m_hist.pop_front());
    end
  end

  always @(negedge clk) begin : compare
    if (m_valid) begin
      chk("req",         32'(req),         32'(m_req));
      chk("data_out",    32'(data_out),    32'(m_dout));
      chk("level",       32'(level),       32'(m_q.size()));
      chk("full",        32'(full),        32'(m_q.size() == int'(DEPTH)));
      chk("overflow",    32'(overflow),    32'(m_ovf));
      chk("busy",        32'(busy),        32'(m_phase != P_IDLE));
      chk("timeout_err", 32'(timeout_err), 32'(m_terr));
      chk("sent_count",  32'(sent_count),  32'(m_sent));
    end
  end

  // Peripheral responder: 0 follows req after r_delay cycles, 1 never acks, 2 acks and sticks, 3 holds ack high.
  int r_mode = 0, r_delay = 0, r_cnt = 0;
  always @(negedge clk) begin : responder
    #2;
    case (r_mode)
      0: if (req !== ack) begin
           if (r_cnt >= r_delay) begin ack = req; r_cnt = 0; end
           else r_cnt++;
         end else r_cnt = 0;
      1: ack = 1'b0;
      2: if (req === 1'b1) ack = 1'b1;
      default: ack = 1'b1;
    endcase
  end

  logic [DATA_W-1:0] seen[$];
  logic req_prev = 1'b0;
  always @(negedge clk) begin : link_monitor
    if (req === 1'b1 && req_prev !== 1'b1) seen.push_back(data_out);
    req_prev = req;
  end

  task automatic push(input logic [DATA_W-1:0] d);
    wr_en = 1'b1; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((busy !== 1'b0 || level !== 3'd0) && n < 300) begin @(negedge clk); n++; end
    chk({nm, "_drain_bound"}, 32'(n < 300), 32'd1);
  endtask

  task automatic send_one(input logic [DATA_W-1:0] d);
    logic [CNT_W-1:0] s;
    int n = 0;
    s = sent_count;
    push(d);
    while (sent_count === s && n < 100) begin @(negedge clk); n++; end
    chk("send_one_bound", 32'(n < 100), 32'd1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin : stimulus
    logic [DATA_W-1:0] w[6];
    logic [CNT_W-1:0]  s0, diff;
    int n;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req",   32'(req), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_sent",  32'(sent_count), 32'd0);
    chk("rst_dout",  32'(data_out), 32'd0);

    // Single word with a 3-cycle responder.
    r_mode = 0; r_delay = 3; seen.delete();
    push(8'hA5);
    chk("t1_level_k", 32'(level), 32'd1);
    chk("t1_req_k",   32'(req), 32'd0);
    @(negedge clk);
    chk("t1_req_k1",  32'(req), 32'd1);
    chk("t1_dout",    32'(data_out), 32'hA5);
    wait_idle("t1");
    chk("t1_sent",    32'(sent_count), 32'd1);
    chk("t1_seen_n",  32'(seen.size()), 32'd1);
    if (seen.size() > 0) chk("t1_seen0", 32'(seen[0]), 32'hA5);

    // Burst of six while the link is held off: four fit, two overflow.
    r_mode = 3;
    repeat (4) @(negedge clk);
    seen.delete(); s0 = sent_count;
    for (int i = 0; i < 6; i++) begin
      w[i] = DATA_W'($urandom);
      push(w[i]);
      if (i == 3) chk("t2_ovf_4th", 32'(overflow), 32'd0);
      if (i == 4) chk("t2_ovf_5th", 32'(overflow), 32'd1);
    end
    chk("t2_level", 32'(level), 32'd4);
    chk("t2_full",  32'(full), 32'd1);
    r_mode = 0; r_delay = $urandom_range(0, 2);
    wait_idle("t2");
    chk("t2_seen_n", 32'(seen.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (seen.size() > i) chk("t2_order", 32'(seen[i]), 32'(w[i]));
    diff = sent_count - s0;
    chk("t2_sent_delta", 32'(diff), 32'd4);
    pulse_clear();
    chk("t2_ovf_clr", 32'(overflow), 32'd0);

    // Peripheral never acks: timeout in REQ.
    r_mode = 1; s0 = sent_count;
    push(DATA_W'($urandom));
    n = 0;
    while (req !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    chk("t3_req_rise", 32'(req), 32'd1);
    n = 0;
    while (timeout_err !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("t3_cycles", 32'(n), 32'd10);
    chk("t3_req_low", 32'(req), 32'd0);
    pulse_clear();
    chk("t3_terr_clr", 32'(timeout_err), 32'd0);
    chk("t3_idle", 32'(busy), 32'd0);
    chk("t3_sent", 32'(sent_count), 32'(s0));

    // Ack stuck high: timeout in DROP, ERR held until ack_s falls.
    r_mode = 2; s0 = sent_count;
    push(DATA_W'($urandom));
    n = 0;
    while (timeout_err !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    chk("t4_terr", 32'(timeout_err), 32'd1);
    chk("t4_req", 32'(req), 32'd0);
    pulse_clear();
    chk("t4_err_held", 32'(busy), 32'd1);
    chk("t4_terr_clr", 32'(timeout_err), 32'd0);
    r_mode = 0; r_delay = 0;
    repeat (4) @(negedge clk);
    chk("t4_still_err", 32'(busy), 32'd1);
    pulse_clear();
    chk("t4_idle", 32'(busy), 32'd0);
    chk("t4_sent", 32'(sent_count), 32'(s0));

    // Reset while in REQ with three words queued.
    r_mode = 1;
    for (int i = 0; i < 4; i++) push(DATA_W'($urandom));
    chk("t5_level_pre", 32'(level), 32'd3);
    chk("t5_req_pre", 32'(req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_req", 32'(req), 32'd0);
    chk("t5_level", 32'(level), 32'd0);
    chk("t5_sent", 32'(sent_count), 32'd0);

    // Push and pop in the same cycle at level DEPTH-1.
    r_mode = 3;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) push(DATA_W'($urandom));
    r_mode = 0; r_delay = 0;
    repeat (2) @(negedge clk);
    chk("t6_level_pre", 32'(level), 32'd3);
    chk("t6_req_pre", 32'(req), 32'd0);
    push(DATA_W'($urandom));
    chk("t6_level", 32'(level), 32'd3);
    chk("t6_full", 32'(full), 32'd0);
    chk("t6_req", 32'(req), 32'd1);
    wait_idle("t6");

    // Random traffic, responder delays and error clears.
    for (int i = 0; i < 80; i++) begin
      r_delay   = $urandom_range(0, 4);
      wr_en     = ($urandom_range(0, 2) == 0);
      wr_data   = DATA_W'($urandom);
      clear_err = ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    wr_en = 1'b0; clear_err = 1'b0;
    wait_idle("rand");

    // Sent counter wraps from 15 to 0.
    r_delay = 1; n = 0;
    while (sent_count !== 4'd15 && n < 20) begin send_one(DATA_W'($urandom)); n++; end
    chk("wrap_15", 32'(sent_count), 32'd15);
    send_one(DATA_W'($urandom));
    chk("wrap_0", 32'(sent_count), 32'd0);
    wait_idle("wrap");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
